// File: rtl/key_enc_debounce.sv
// Purpose : synchronise, debounce and edge-detect two active-low push-buttons
//           and a 4-bit active-low switch vector; present clean active-high
//           levels plus single-cycle press/release/long-press/change strobes.
// Latency : DB_CNT+2 clk cycles from the first raw sample of a new level to
//           the debounced level and its strobe (2 synchroniser stages, then
//           DB_CNT+1 consecutive agreeing samples in the decision logic).
// Backpressure: none; strobes are one-cycle pulses and must be consumed when
//           they appear.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low
//   key0/key1  raw buttons, active-low (0 = pressed)
//   enc[3:0]   raw switch vector, active-low per bit
//   key_lvl    debounced pressed level per key (1 = pressed)
//   key_press  one-cycle strobe on debounced press
//   key_rel    one-cycle strobe on debounced release
//   key_long   one-cycle strobe once a press has been held LONG_CNT cycles
//   enc_val    debounced switch value, active-high
//   enc_chg    one-cycle strobe whenever enc_val updates

module key_enc_debounce #(
  parameter int unsigned DB_CNT   = 1_000_000,  // debounce window, clk cycles
  parameter int unsigned LONG_CNT = 50_000_000  // long-press hold, clk cycles
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key0,
  input  logic       key1,
  input  logic [3:0] enc,
  output logic [1:0] key_lvl,
  output logic [1:0] key_press,
  output logic [1:0] key_rel,
  output logic [1:0] key_long,
  output logic [3:0] enc_val,
  output logic       enc_chg
);

  // Terminal counts, sized to the counter registers they are compared with.
  localparam logic [23:0] DB_LAST   = 24'(DB_CNT - 1);
  localparam logic [27:0] LONG_LAST = 28'(LONG_CNT - 1);
  localparam logic [27:0] LONG_SAT  = 28'(LONG_CNT);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser on every raw pin. Bits [1:0] are the keys, [5:2]
  // the switch vector. Reset value is the released level (all ones) so that
  // nothing downstream sees a phantom press while reset is active.
  // ---------------------------------------------------------------------------
  logic [5:0] raw;
  logic [5:0] sync1;
  logic [5:0] sync2;

  assign raw = {enc, key1, key0};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Decision logic works in active-high terms from here on.
  logic [1:0] key_smp;
  logic [3:0] enc_smp;

  assign key_smp = ~sync2[1:0];
  assign enc_smp = ~sync2[5:2];

  // ---------------------------------------------------------------------------
  // Per-key FSM: state register / next-state logic / output logic.
  // ---------------------------------------------------------------------------
  key_state_t  st_q   [2];
  key_state_t  st_d   [2];
  logic [23:0] dcnt_q [2];
  logic [23:0] dcnt_d [2];
  logic [27:0] hcnt_q [2];
  logic [27:0] hcnt_d [2];

  logic [1:0]  press_d;
  logic [1:0]  rel_d;
  logic [1:0]  long_d;
  logic [1:0]  press_q;
  logic [1:0]  rel_q;
  logic [1:0]  long_q;

  // State register. Strobes are registered so they line up with the level
  // change they announce (both become visible after the same edge).
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= IDLE;
        dcnt_q[i] <= '0;
        hcnt_q[i] <= '0;
      end
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= st_d[i];
        dcnt_q[i] <= dcnt_d[i];
        hcnt_q[i] <= hcnt_d[i];
      end
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  // Next-state logic.
  always_comb begin
    press_d = '0;
    rel_d   = '0;
    long_d  = '0;
    for (int i = 0; i < 2; i++) begin
      st_d[i]   = st_q[i];
      dcnt_d[i] = dcnt_q[i];
      hcnt_d[i] = hcnt_q[i];

      case (st_q[i])
        IDLE: begin
          if (key_smp[i]) begin
            st_d[i]   = PRESS_WAIT;
            dcnt_d[i] = '0;
          end
        end

        PRESS_WAIT: begin
          if (!key_smp[i]) begin
            // Bounce before the window closed: silently abandon the press.
            st_d[i]   = IDLE;
            dcnt_d[i] = '0;
          end else if (dcnt_q[i] == DB_LAST) begin
            st_d[i]    = HELD;
            dcnt_d[i]  = '0;
            hcnt_d[i]  = '0;
            press_d[i] = 1'b1;
          end else begin
            dcnt_d[i] = dcnt_q[i] + 24'd1;
          end
        end

        HELD: begin
          // The hold counter advances on every HELD cycle, including the one
          // on which a release sample arrives; it saturates one past the
          // long-press terminal so the strobe can only fire once per press.
          if (hcnt_q[i] == LONG_LAST) begin
            long_d[i] = 1'b1;
          end
          if (hcnt_q[i] < LONG_SAT) begin
            hcnt_d[i] = hcnt_q[i] + 28'd1;
          end
          if (!key_smp[i]) begin
            st_d[i]   = RELEASE_WAIT;
            dcnt_d[i] = '0;
          end
        end

        RELEASE_WAIT: begin
          // hcnt is frozen here, so release bounces only postpone key_long.
          if (key_smp[i]) begin
            st_d[i]   = HELD;
            dcnt_d[i] = '0;
          end else if (dcnt_q[i] == DB_LAST) begin
            st_d[i]   = IDLE;
            dcnt_d[i] = '0;
            rel_d[i]  = 1'b1;
          end else begin
            dcnt_d[i] = dcnt_q[i] + 24'd1;
          end
        end

        default: begin
          st_d[i]   = IDLE;
          dcnt_d[i] = '0;
        end
      endcase
    end
  end

  // Output logic. The level is a pure function of state: pressed from the
  // moment the press is accepted until the release is accepted.
  always_comb begin
    key_lvl = '0;
    for (int i = 0; i < 2; i++) begin
      key_lvl[i] = (st_q[i] == HELD) || (st_q[i] == RELEASE_WAIT);
    end
    key_press = press_q;
    key_rel   = rel_q;
    key_long  = long_q;
  end

  // ---------------------------------------------------------------------------
  // Switch vector debounce. One counter shared by all four bits: a new value
  // is first captured as a candidate, then must be seen unchanged for the
  // whole window. Any different value restarts the window with itself as the
  // new candidate; a return to the current value just resets the count.
  // ---------------------------------------------------------------------------
  logic [23:0] ecnt;
  logic [3:0]  cand;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ecnt    <= '0;
      cand    <= '0;
      enc_val <= '0;
      enc_chg <= 1'b0;
    end else begin
      enc_chg <= 1'b0;
      if (enc_smp == enc_val) begin
        ecnt <= '0;
      end else if (enc_smp != cand) begin
        cand <= enc_smp;
        ecnt <= '0;
      end else if (ecnt == DB_LAST) begin
        enc_val <= cand;
        enc_chg <= 1'b1;
        ecnt    <= '0;
      end else begin
        ecnt <= ecnt + 24'd1;
      end
    end
  end

endmodule

// File: tb/tb_key_enc_debounce.sv
module tb_key_enc_debounce;

  localparam int DB   = 4;
  localparam int LONG = 20;

  logic       clk;
  logic       rst;
  logic       key0;
  logic       key1;
  logic [3:0] enc;
  logic [1:0] key_lvl;
  logic [1:0] key_press;
  logic [1:0] key_rel;
  logic [1:0] key_long;
  logic [3:0] enc_val;
  logic       enc_chg;

  key_enc_debounce #(.DB_CNT(DB), .LONG_CNT(LONG)) dut (
    .clk      (clk),
    .rst      (rst),
    .key0     (key0),
    .key1     (key1),
    .enc      (enc),
    .key_lvl  (key_lvl),
    .key_press(key_press),
    .key_rel  (key_rel),
    .key_long (key_long),
    .enc_val  (enc_val),
    .enc_chg  (enc_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed strobe tallies, cleared by the directed steps around a window.
  int n_press [2];
  int n_rel   [2];
  int n_long  [2];
  int n_chg;

  // Reference model. Keys: a debounced level flips after DB+1 consecutive
  // samples disagreeing with it; hold time accumulates only while the key is
  // pressed and no release run is in progress. Switches: a candidate value
  // must be matched DB further times after it is first captured.
  logic [5:0] m_s1, m_s2;
  bit         m_lvl  [2];
  int         m_run  [2];
  int         m_hold [2];
  bit [1:0]   m_press, m_rel, m_long;
  logic [3:0] m_eval, m_cand;
  int         m_erun;
  bit         m_chg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [3:0] v;
    bit s;
    bit held;
    m_press = '0; m_rel = '0; m_long = '0; m_chg = 1'b0;
    if (!rst) begin
      m_s1 = '1; m_s2 = '1;
      for (int k = 0; k < 2; k++) begin
        m_lvl[k] = 1'b0; m_run[k] = 0; m_hold[k] = 0;
      end
      m_eval = '0; m_cand = '0; m_erun = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        s    = ~m_s2[k];
        held = m_lvl[k] && (m_run[k] == 0);
        if (held) begin
          if (m_hold[k] == LONG - 1) m_long[k] = 1'b1;
          if (m_hold[k] < LONG) m_hold[k]++;
        end
        if (s == m_lvl[k]) begin
          m_run[k] = 0;
        end else begin
          m_run[k]++;
          if (m_run[k] == DB + 1) begin
            m_lvl[k] = s;
            m_run[k] = 0;
            if (s) begin m_press[k] = 1'b1; m_hold[k] = 0; end
            else         m_rel[k]   = 1'b1;
          end
        end
      end
      v = ~m_s2[5:2];
      if (v == m_eval) begin
        m_erun = 0;
      end else if (v != m_cand) begin
        m_cand = v; m_erun = 0;
      end else begin
        m_erun++;
        if (m_erun == DB) begin
          m_eval = v; m_chg = 1'b1; m_erun = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {enc, key1, key0};
    end
  endtask

  // One clock: advance the model on the edge, then compare 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", {19'd0, key_lvl, key_press, key_rel, key_long, enc_val, enc_chg},
        {19'd0, m_lvl[1], m_lvl[0], m_press, m_rel, m_long, m_eval, m_chg});
    for (int k = 0; k < 2; k++) begin
      n_press[k] += int'(key_press[k]);
      n_rel[k]   += int'(key_rel[k]);
      n_long[k]  += int'(key_long[k]);
    end
    n_chg += int'(enc_chg);
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic clr_counts();
    for (int k = 0; k < 2; k++) begin
      n_press[k] = 0; n_rel[k] = 0; n_long[k] = 0;
    end
    n_chg = 0;
  endtask

  initial begin
    int seg;
    clr_counts();
    rst = 1'b0; key0 = 1'b1; key1 = 1'b1; enc = 4'hF;
    m_s1 = '1; m_s2 = '1;

    // Reset state.
    run(3);
    chk("reset_outputs", {19'd0, key_lvl, key_press, key_rel, key_long, enc_val, enc_chg}, 32'd0);
    rst = 1'b1;
    run(5);

    // Press latency: low sampled at edge t0, press visible after edge t0+DB+2.
    key0 = 1'b0;
    run(DB + 2);
    chk("press_early", key_press, 2'b00);
    run(1);
    chk("press_strobe", key_press, 2'b01);
    chk("press_level", key_lvl, 2'b01);
    run(1);
    chk("press_once", key_press, 2'b00);

    // Long press lands LONG cycles after the press strobe (now at P+1).
    clr_counts();
    run(LONG - 2);
    chk("long_early", key_long, 2'b00);
    run(1);
    chk("long_strobe", key_long, 2'b01);
    run(20);
    chk("long_count", n_long[0], 1);

    // Release latency.
    key0 = 1'b1;
    run(DB + 2);
    chk("rel_early", {key_rel, key_lvl}, 4'b0001);
    run(1);
    chk("rel_strobe", {key_rel, key_lvl}, 4'b0100);
    run(4);

    // Short glitch on key1: no effect at all.
    clr_counts();
    key1 = 1'b0; run(DB - 1);
    key1 = 1'b1; run(10);
    chk("glitch_strobes", n_press[1] + n_rel[1], 0);
    chk("glitch_level", key_lvl, 2'b00);

    // Two-cycle release bounce while held delays key_long by two cycles.
    key0 = 1'b0;
    run(DB + 3);
    chk("bounce_press", key_press, 2'b01);
    clr_counts();
    run(5);
    key0 = 1'b1; run(2);
    key0 = 1'b0; run(LONG - 6);
    chk("bounce_long_early", key_long, 2'b00);
    run(1);
    chk("bounce_long", key_long, 2'b01);
    run(20);
    chk("bounce_no_rel", n_rel[0], 0);
    chk("bounce_long_count", n_long[0], 1);
    chk("bounce_no_repress", n_press[0], 0);
    key0 = 1'b1;
    run(DB + 6);

    // Switch vector: F -> A gives enc_val 5 after DB+2 cycles.
    clr_counts();
    enc = 4'hA;
    run(DB + 2);
    chk("enc_early", {enc_val, enc_chg}, 5'h00);
    run(1);
    chk("enc_update", {enc_val, enc_chg}, {4'h5, 1'b1});
    run(3);
    chk("enc_chg_once", n_chg, 1);

    // A/B toggling every 2 cycles never settles.
    clr_counts();
    for (int j = 0; j < 10; j++) begin
      enc = (j % 2 == 0) ? 4'hB : 4'hA;
      run(2);
    end
    enc = 4'hA;
    run(8);
    chk("enc_toggle_chg", n_chg, 0);
    chk("enc_toggle_val", enc_val, 4'h5);

    // Simultaneous presses.
    key0 = 1'b0; key1 = 1'b0;
    run(DB + 3);
    chk("dual_press", key_press, 2'b11);
    key0 = 1'b1; key1 = 1'b1;
    run(DB + 3);
    chk("dual_rel", key_rel, 2'b11);
    run(2);

    // Reset while held, key still low afterwards: fresh press.
    key0 = 1'b0;
    run(DB + 8);
    chk("pre_reset_held", key_lvl, 2'b01);
    rst = 1'b0;
    run(1);
    chk("mid_reset", {19'd0, key_lvl, key_press, key_rel, key_long, enc_val, enc_chg}, 32'd0);
    rst = 1'b1;
    run(DB + 2);
    chk("post_reset_early", key_press, 2'b00);
    run(1);
    chk("post_reset_press", key_press, 2'b01);
    key0 = 1'b1;
    run(DB + 4);

    // Random segments: hold random levels for random lengths so both bounces
    // and long stable holds occur; occasional one-cycle resets.
    for (int j = 0; j < 300; j++) begin
      if ($urandom_range(0, 9) < 6) key0 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 6) key1 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 4) enc  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0; run(1); rst = 1'b1;
      end
      seg = (j % 3 == 0) ? int'($urandom_range(15, 30)) : int'($urandom_range(1, 6));
      run(seg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_enc_debounce.md
# key_enc_debounce

Input conditioner for the board's push-buttons and 4-bit DIP/encoder switch; it sits between the raw FPGA pins and the counter/LED display logic. It synchronises the raw active-low inputs, debounces each one, and presents clean active-high levels. It also emits single-cycle press, release, long-press and switch-change strobes, so downstream logic never needs its own edge detectors.

## Interface
- DB_CNT, 1_000_000: debounce window in clk cycles (20 ms at 50 MHz); legal range 2 .. 2^24-1.
- LONG_CNT, 50_000_000: hold time in clk cycles for a long-press; must exceed DB_CNT; legal range up to 2^28-1.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- key0  in  1  raw button 0, active-low (0 = pressed).
- key1  in  1  raw button 1, active-low.
- enc  in  4  raw switch vector, active-low per bit.
- key_lvl  out  2  debounced pressed level, bit i = key i, 1 = pressed.
- key_press  out  2  one-cycle strobe on debounced press.
- key_rel  out  2  one-cycle strobe on debounced release.
- key_long  out  2  one-cycle strobe when held LONG_CNT cycles.
- enc_val  out  4  debounced switch value, active-high (= ~enc when stable).
- enc_chg  out  1  one-cycle strobe when enc_val updates.

## Operation
- Every raw input passes through a 2-flop synchroniser. On reset the synchroniser flops take the released value 1; the FSM and decision logic see only the second flop.
- Each key has an independent FSM with a debounce counter dcnt (24 b) and a hold counter hcnt (28 b).
  - IDLE: key_lvl=0. A pressed sample moves the FSM to PRESS_WAIT with dcnt=0.
  - PRESS_WAIT: if the sample is still pressed, dcnt increments. When dcnt==DB_CNT-1 with the sample still pressed, the FSM moves to HELD, sets key_lvl=1, pulses key_press and sets hcnt=0. A released sample returns the FSM to IDLE with dcnt=0 and no strobe.
  - HELD: hcnt increments and saturates. key_long pulses exactly once, on the cycle hcnt reaches LONG_CNT-1. A released sample moves the FSM to RELEASE_WAIT with dcnt=0.
  - RELEASE_WAIT: key_lvl stays 1 and hcnt holds its value.
    - Released for DB_CNT consecutive samples: the FSM moves to IDLE, clears key_lvl and pulses key_rel.
    - Pressed sample (bounce): the FSM returns to HELD. No key_press is issued, and hcnt resumes from its held value.
- Switch vector: one shared counter ecnt (24 b) and a 4-bit candidate register cand.
  - Synchronised (inverted) value == enc_val: ecnt=0.
  - Value differs from enc_val and != cand: cand loads the value and ecnt=0.
  - Value differs from enc_val and == cand: ecnt increments. At ecnt==DB_CNT-1, enc_val loads cand, enc_chg pulses and ecnt clears.
- Keys and switches are fully independent; simultaneous events on any channels produce simultaneous strobes.

## Timing
- Reset values: all outputs 0, every FSM in IDLE, all counters 0, cand=0.
- Press latency: if raw key is first sampled low at edge t0 and stays low, key_lvl rises and key_press is high for the cycle after edge t0+DB_CNT+2.
- Release latency: same rule, DB_CNT+2 cycles from the first low-to-high sample.
- enc_val/enc_chg latency: DB_CNT+2 cycles from the first stable sample of the new value.
- Each strobe is high for exactly one cycle per event and never repeats while the level holds.
- key_long fires LONG_CNT cycles after key_press, plus any cycles spent in RELEASE_WAIT bounces (hcnt pauses there).
- Reset mid-operation: all state clears on the next clk edge with no strobes. A key still held after reset deasserts is treated as a new press: key_press arrives after DB_CNT+2 cycles.
- A glitch shorter than DB_CNT cycles produces no output change on any channel.

## Test plan
- DB_CNT=4, LONG_CNT=20. Hold key0 low from cycle 10 -> key_lvl[0]=1 and key_press[0] high for one cycle at cycle 16. Release at cycle 30 -> key_rel[0] pulses at cycle 36.
- key1 low for 3 cycles, then high -> no change on key_lvl[1], key_press[1] or key_rel[1].
- key0 held 40 cycles -> exactly one key_long[0] pulse, 20 cycles after key_press[0]. A 2-cycle high bounce mid-hold -> no key_rel, and key_long is delayed by 2 cycles.
- enc raw 4'hF -> 4'hA (held) -> enc_val=4'h5 with one enc_chg pulse after 6 cycles. Toggling between 4'hA and 4'hB every 2 cycles -> enc_val unchanged and no enc_chg.
- key0 and key1 pressed on the same cycle -> both key_press bits high in the same cycle.
- Assert rst for 1 cycle while key0 is in HELD -> all outputs 0 next cycle. With key0 still low, key_press[0] re-pulses 6 cycles after rst deasserts.
